// File: rtl/ooo_completion_buffer.sv
// In-order completion buffer: dispatch allocates at tail, execute units write back
// by index, head retires one entry per cycle and raises a flush on an exception.
module ooo_completion_buffer #(
  parameter int NUM_CB_ENTRY = 16,
  parameter int NUM_WB       = 4,
  parameter int IDXW         = $clog2(NUM_CB_ENTRY)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   alloc_req,
  input  logic [4:0]             alloc_rd,
  output logic                   alloc_ready,
  output logic [IDXW-1:0]        alloc_index,
  input  logic [NUM_WB-1:0]      wb_done,
  input  logic [NUM_WB*IDXW-1:0] wb_index,
  input  logic [NUM_WB-1:0]      wb_wen,
  input  logic [NUM_WB*32-1:0]   wb_wdata,
  input  logic [NUM_WB-1:0]      wb_exception,
  output logic                   retire_valid,
  output logic [IDXW-1:0]        retire_index,
  output logic                   rf_wen,
  output logic [4:0]             rf_rd,
  output logic [31:0]            rf_wdata,
  output logic                   exception_out,
  output logic                   flush,
  output logic [IDXW:0]          count,
  output logic                   empty
);
  localparam logic [IDXW:0] PTR_ONE = 1;

  logic [NUM_CB_ENTRY-1:0]       valid_q, done_q, wen_q, exc_q;
  logic [NUM_CB_ENTRY-1:0][4:0]  rd_q;
  logic [NUM_CB_ENTRY-1:0][31:0] wdata_q;
  logic [IDXW:0]                 head_q, tail_q;
  logic [NUM_WB-1:0][IDXW-1:0]   wb_idx;
  logic [NUM_WB-1:0][31:0]       wb_data;
  logic [IDXW-1:0]               hp, tp;
  logic                          full, alloc_fire, retire_now, head_exc;

  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
    assign wb_idx[k]  = wb_index[k*IDXW +: IDXW];
    assign wb_data[k] = wb_wdata[k*32 +: 32];
  end

  assign hp          = head_q[IDXW-1:0];
  assign tp          = tail_q[IDXW-1:0];
  assign full        = (hp == tp) && (head_q[IDXW] != tail_q[IDXW]);
  // Slot freed by a same-cycle retire is only visible next cycle.
  assign alloc_ready = !RST && !full && !flush;
  assign alloc_index = tp;
  assign alloc_fire  = alloc_req && alloc_ready;
  assign retire_now  = valid_q[hp] && done_q[hp];
  assign head_exc    = exc_q[hp];
  assign count       = tail_q - head_q;
  assign empty       = (count == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      done_q  <= '0;
      wen_q   <= '0;
      exc_q   <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else if (retire_now && head_exc) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      // Descending order so the lowest-numbered unit's write lands last and wins.
      for (int k = NUM_WB-1; k >= 0; k--) begin
        if (wb_done[k] && valid_q[wb_idx[k]]) begin
          done_q[wb_idx[k]]  <= 1'b1;
          wen_q[wb_idx[k]]   <= wb_wen[k];
          exc_q[wb_idx[k]]   <= wb_exception[k];
          wdata_q[wb_idx[k]] <= wb_data[k];
        end
      end
      if (retire_now) begin
        valid_q[hp] <= 1'b0;
        done_q[hp]  <= 1'b0;
      end
      if (alloc_fire) begin
        valid_q[tp] <= 1'b1;
        done_q[tp]  <= 1'b0;
        exc_q[tp]   <= 1'b0;
        rd_q[tp]    <= alloc_rd;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q        <= '0;
      tail_q        <= '0;
      retire_valid  <= 1'b0;
      retire_index  <= '0;
      rf_wen        <= 1'b0;
      rf_rd         <= '0;
      rf_wdata      <= '0;
      exception_out <= 1'b0;
      flush         <= 1'b0;
    end else begin
      retire_valid  <= retire_now;
      rf_wen        <= retire_now && wen_q[hp] && (rd_q[hp] != 5'd0) && !head_exc;
      exception_out <= retire_now && head_exc;
      flush         <= retire_now && head_exc;
      if (retire_now) begin
        retire_index <= hp;
        rf_rd        <= rd_q[hp];
        rf_wdata     <= wdata_q[hp];
      end
      if (retire_now && head_exc) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (retire_now) head_q <= head_q + PTR_ONE;
        if (alloc_fire) tail_q <= tail_q + PTR_ONE;
      end
    end
  end
endmodule

// File: tb/tb_ooo_completion_buffer.sv
// Scoreboard bench: allocations queue expected retirements in program order,
// writeback stimulus fills the per-index model, the monitor pops on each retire.
module tb_ooo_completion_buffer;
  localparam int N  = 16;
  localparam int NW = 4;
  localparam int IW = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            alloc_req;
  logic [4:0]      alloc_rd;
  logic            alloc_ready;
  logic [IW-1:0]   alloc_index;
  logic [NW-1:0]   wb_done, wb_wen, wb_exception;
  logic [NW*IW-1:0] wb_index;
  logic [NW*32-1:0] wb_wdata;
  logic            retire_valid, rf_wen, exception_out, flush, empty;
  logic [IW-1:0]   retire_index;
  logic [4:0]      rf_rd;
  logic [31:0]     rf_wdata;
  logic [IW:0]     count;

  typedef struct packed { logic [IW-1:0] idx; logic [4:0] rd; } exp_t;
  exp_t        sb_q[$];
  exp_t        pend[$];
  exp_t        mon_e;
  logic [31:0] m_data [N];
  logic        m_wen  [N];
  logic        m_exc  [N];
  logic [IW-1:0] exp_tail;
  logic [IW-1:0] cur;
  int n_tests = 0;
  int n_fail  = 0;

  ooo_completion_buffer #(.NUM_CB_ENTRY(N), .NUM_WB(NW)) dut (
    .CLK(CLK), .RST(RST),
    .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .wb_done(wb_done), .wb_index(wb_index), .wb_wen(wb_wen), .wb_wdata(wb_wdata),
    .wb_exception(wb_exception),
    .retire_valid(retire_valid), .retire_index(retire_index), .rf_wen(rf_wen), .rf_rd(rf_rd),
    .rf_wdata(rf_wdata), .exception_out(exception_out), .flush(flush), .count(count), .empty(empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd);
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_index", alloc_index, exp_tail);
    sb_q.push_back('{idx: exp_tail, rd: rd});
    m_data[exp_tail] = '0;
    m_wen[exp_tail]  = 1'b0;
    m_exc[exp_tail]  = 1'b0;
    alloc_req = 1'b1;
    alloc_rd  = rd;
    tick();
    alloc_req = 1'b0;
    exp_tail++;
  endtask

  task automatic wb_set(input int k, input logic [IW-1:0] idx, input logic [31:0] d,
                        input logic en, input logic ex);
    wb_done[k]            = 1'b1;
    wb_index[k*IW +: IW]  = idx;
    wb_wdata[k*32 +: 32]  = d;
    wb_wen[k]             = en;
    wb_exception[k]       = ex;
  endtask

  task automatic wb_clr();
    wb_done      = '0;
    wb_wen       = '0;
    wb_exception = '0;
  endtask

  task automatic wb1(input int k, input logic [IW-1:0] idx, input logic [31:0] d,
                     input logic en, input logic ex);
    wb_set(k, idx, d, en, ex);
    m_data[idx] = d;
    m_wen[idx]  = en;
    m_exc[idx]  = ex;
    tick();
    wb_clr();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (sb_q.size() != 0 && c < maxc) begin
      @(negedge CLK);
      #1;
      c++;
    end
    chk("drain_timeout", sb_q.size(), 0);
  endtask

  // Retire monitor: every negedge either checks a retirement or the idle outputs.
  always @(negedge CLK) begin
    if (!RST) begin
      if (retire_valid) begin
        if (sb_q.size() == 0) chk("unexp_retire", retire_valid, 0);
        else begin
          mon_e = sb_q.pop_front();
          chk("ret_idx",   retire_index, mon_e.idx);
          chk("ret_rd",    rf_rd, mon_e.rd);
          chk("ret_data",  rf_wdata, m_data[mon_e.idx]);
          chk("ret_wen",   rf_wen, m_wen[mon_e.idx] && (mon_e.rd != 0) && !m_exc[mon_e.idx]);
          chk("ret_exc",   exception_out, m_exc[mon_e.idx]);
          chk("ret_flush", flush, m_exc[mon_e.idx]);
          if (m_exc[mon_e.idx]) sb_q.delete();
        end
      end else begin
        chk("idle_rfwen", rf_wen, 0);
        chk("idle_exc",   exception_out, 0);
        chk("idle_flush", flush, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; alloc_req = 1'b0; alloc_rd = '0;
    wb_done = '0; wb_wen = '0; wb_exception = '0; wb_index = '0; wb_wdata = '0;
    exp_tail = '0;
    for (int i = 0; i < N; i++) begin m_data[i] = '0; m_wen[i] = 0; m_exc[i] = 0; end
    #1;
    chk("rst_ready", alloc_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rv",    retire_valid, 0);
    repeat (2) tick();
    RST = 1'b0;
    #1;
    chk("post_rst_ready", alloc_ready, 1);

    // Out-of-order writeback, in-order retire
    alloc(5'd1); alloc(5'd2); alloc(5'd3);
    chk("count3", count, 3);
    wb1(0, 4'd2, 32'h33, 1, 0);
    wb1(1, 4'd0, 32'h11, 1, 0);
    wb1(2, 4'd1, 32'h22, 1, 0);
    drain(20);
    chk("empty_after3", empty, 1);

    // Fill to full, ignored extra request, one retire frees a slot
    for (int i = 0; i < N; i++) alloc(5'(i + 5));
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    alloc_req = 1'b1; alloc_rd = 5'd30;
    tick();
    alloc_req = 1'b0;
    chk("ignored_count", count, 16);
    chk("ignored_index", alloc_index, exp_tail);
    wb1(0, sb_q[0].idx, 32'hF00D, 1, 0);
    chk("still_full", alloc_ready, 0);
    tick();
    chk("freed_ready", alloc_ready, 1);
    @(negedge CLK); #1;
    pend = sb_q;
    foreach (pend[j]) wb1(j % NW, pend[j].idx, 32'h1000 + 32'(j), 1, 0);
    drain(40);

    // 40 alloc/retire pairs wrapping the index space
    for (int i = 0; i < 40; i++) begin
      cur = exp_tail;
      alloc(5'((i % 31) + 1));
      wb1(i % NW, cur, 32'(i) * 32'h01010101 + 32'd5, (i % 3) != 0, 0);
    end
    drain(20);
    chk("wrap_count", count, 0);

    // Same-index collision and writeback to an unallocated entry
    for (int i = 0; i < 8; i++) alloc(5'(i + 10));
    wb_set(0, 4'd2, 32'hAAAA, 1, 0);
    wb_set(3, 4'd2, 32'h5555, 1, 0);
    m_data[2] = 32'hAAAA; m_wen[2] = 1; m_exc[2] = 0;
    tick();
    wb_clr();
    wb_set(1, 4'd9, 32'hBEEF, 1, 0);
    tick();
    wb_clr();
    pend = sb_q;
    foreach (pend[j]) if (pend[j].idx != 4'd2) wb1(j % NW, pend[j].idx, 32'h2000 + 32'(j), 1, 0);
    drain(30);
    chk("coll_count", count, 0);
    chk("coll_empty", empty, 1);

    // Move head to 1, then exception on idx1 with tail=5
    for (int i = 0; i < 14; i++) begin
      cur = exp_tail;
      alloc(5'd7);
      wb1(0, cur, 32'h3000 + 32'(i), 1, 0);
    end
    drain(20);
    chk("exc_head_pos", alloc_index, 1);
    for (int i = 0; i < 4; i++) alloc(5'(i + 1));
    wb1(3, 4'd2, 32'h22, 1, 0);
    wb1(2, 4'd1, 32'hE1, 1, 1);
    drain(20);
    chk("flush_hi",      flush, 1);
    chk("flush_ready",   alloc_ready, 0);
    chk("flush_count",   count, 0);
    chk("flush_empty",   empty, 1);
    chk("flush_aidx",    alloc_index, 0);
    exp_tail = '0;
    alloc_req = 1'b1; alloc_rd = 5'd4;
    tick();
    alloc_req = 1'b0;
    chk("flush_lo",      flush, 0);
    chk("flush_nalloc",  count, 0);
    chk("post_flush_rdy", alloc_ready, 1);

    // rd=0 never writes the register file
    alloc(5'd0);
    wb1(1, 4'd0, 32'hDEAD, 1, 0);
    drain(10);

    // Async reset mid-stream
    for (int i = 0; i < 8; i++) alloc(5'(i + 20));
    wb1(0, 4'd1, 32'h77, 1, 0);
    @(posedge CLK); #2;
    chk("pre_rst_rv",    retire_valid, 1);
    chk("pre_rst_count", count, 7);
    RST = 1'b1;
    #1;
    chk("arst_rv",    retire_valid, 0);
    chk("arst_data",  rf_wdata, 0);
    chk("arst_rd",    rf_rd, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ready", alloc_ready, 0);
    sb_q.delete();
    exp_tail = '0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    alloc(5'd9);
    wb1(2, 4'd0, 32'h99, 1, 0);
    drain(10);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
